uart_cmd_ctrl: RTL



---
 rtl/pid_uart_pkg.sv | 41 ++++
 rtl/uart_cmd_ctrl_if.sv | 24 ++
 rtl/uart_tx_seq.sv | 94 +++++++++
 rtl/uart_cmd_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pid_uart_pkg.sv
// Shared constants, FSM encodings and the reply payload for the UART command controller.
package pid_uart_pkg;

  localparam logic [7:0] SOF    = 8'hA5;
  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  localparam logic [1:0] ADDR_KP = 2'd0;
  localparam logic [1:0] ADDR_KI = 2'd1;
  localparam logic [1:0] ADDR_KD = 2'd2;
  localparam logic [1:0] ADDR_SP = 2'd3;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_CMD,
    ST_ADDR,
    ST_DH,
    ST_DL,
    ST_CHK,
    ST_EXEC,
    ST_TX
  } ctrl_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_BUSY,
    TX_DONE
  } tx_state_e;

  // Reply to the host: 1 byte (ACK/NAK) or 3 bytes (read-back).
  typedef struct packed {
    logic [1:0] len;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
  } reply_t;

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// UART-side signals of the command controller: receiver byte stream and transmitter handshake.
interface uart_cmd_ctrl_if;
  logic [7:0] rx_byte;
  logic       rx_rdy;
  logic       send_rdy;
  logic       send;
  logic [7:0] send_data;

  modport master (
    input  rx_byte,
    input  rx_rdy,
    input  send_rdy,
    output send,
    output send_data
  );

  modport slave (
    output rx_byte,
    output rx_rdy,
    output send_rdy,
    input  send,
    input  send_data
  );
endinterface

// File: rtl/uart_tx_seq.sv
// Sends a latched 1- or 3-byte reply through the UART transmitter handshake, pulses done at the end.
module uart_tx_seq
  import pid_uart_pkg::*;
(
  input  logic       clk_in,
  input  logic       reset,
  input  logic       start,
  input  reply_t     reply,
  input  logic       send_rdy,
  output logic       send,
  output logic [7:0] send_data,
  output logic       done
);

  tx_state_e  state_q, state_d;
  reply_t     rbuf_q, rbuf_d;
  logic [1:0] idx_q, idx_d;
  logic       send_d;
  logic [7:0] data_d;
  logic       done_d;
  logic [7:0] cur_byte_c;

  always_comb begin
    cur_byte_c = rbuf_q.b0;
    case (idx_q)
      2'd1:    cur_byte_c = rbuf_q.b1;
      2'd2:    cur_byte_c = rbuf_q.b2;
      default: cur_byte_c = rbuf_q.b0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q   <= TX_IDLE;
      rbuf_q    <= '0;
      idx_q     <= 2'd0;
      send      <= 1'b0;
      send_data <= 8'h00;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rbuf_q    <= rbuf_d;
      idx_q     <= idx_d;
      send      <= send_d;
      send_data <= data_d;
      done      <= done_d;
    end
  end

  // send is held until the slower UART clock domain acknowledges by dropping send_rdy.
  always_comb begin
    state_d = state_q;
    rbuf_d  = rbuf_q;
    idx_d   = idx_q;
    send_d  = send;
    data_d  = send_data;
    done_d  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (start) begin
          rbuf_d  = reply;
          idx_d   = 2'd0;
          state_d = TX_LOAD;
        end
      end
      TX_LOAD: begin
        if (send_rdy) begin
          send_d  = 1'b1;
          data_d  = cur_byte_c;
          state_d = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (!send_rdy) begin
          send_d  = 1'b0;
          state_d = TX_DONE;
        end
      end
      TX_DONE: begin
        if (send_rdy) begin
          if (2'(idx_q + 2'd1) == rbuf_q.len) begin
            done_d  = 1'b1;
            state_d = TX_IDLE;
          end else begin
            idx_d   = 2'(idx_q + 2'd1);
            state_d = TX_LOAD;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses framed host commands from UART bytes, reads/writes the PID tuning registers
// and sequences ACK/NAK or read-back replies.
module uart_cmd_ctrl
  import pid_uart_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1_000_000,
  parameter logic [15:0] KP_RST  = 16'h0100,
  parameter logic [15:0] KI_RST  = 16'h0000,
  parameter logic [15:0] KD_RST  = 16'h0000,
  parameter logic [15:0] SP_RST  = 16'h0000
) (
  input  logic              clk_in,
  input  logic              reset,
  uart_cmd_ctrl_if.master   bus,
  output logic [15:0]       kp,
  output logic [15:0]       ki,
  output logic [15:0]       kd,
  output logic [15:0]       setpoint,
  output logic              cfg_upd,
  output logic [7:0]        err_cnt
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  ctrl_state_e state_q, state_d;
  logic             rx_rdy_q;
  logic [TMO_W-1:0] tmo_q;
  logic [7:0]       cmd_q, addr_q, dh_q, dl_q, chk_q, chk_acc_q;

  logic        rx_edge_c, in_frame_c, tmo_hit_c, byte_ok_c;
  logic        cmd_ok_c, frame_ok_c, wr_en_c, tx_start_c, tx_done;
  logic [15:0] rd_val_c;
  reply_t      reply_c;

  assign rx_edge_c  = bus.rx_rdy & ~rx_rdy_q;
  assign in_frame_c = state_q inside {ST_CMD, ST_ADDR, ST_DH, ST_DL, ST_CHK};
  assign tmo_hit_c  = in_frame_c && (tmo_q == TMO_W'(TIMEOUT - 1));
  // Bytes outside HUNT..CHK (half-duplex) or on the timeout cycle are dropped.
  assign byte_ok_c  = rx_edge_c && (in_frame_c || state_q == ST_HUNT) && !tmo_hit_c;

  assign cmd_ok_c   = (cmd_q == CMD_WR) || (cmd_q == CMD_RD);
  assign frame_ok_c = cmd_ok_c && (addr_q < 8'd4) && (chk_q == chk_acc_q);
  assign wr_en_c    = (state_q == ST_EXEC) && frame_ok_c && (cmd_q == CMD_WR);
  assign tx_start_c = (state_q == ST_EXEC);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q  <= ST_HUNT;
      rx_rdy_q <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      rx_rdy_q <= bus.rx_rdy;
      if (!in_frame_c || byte_ok_c || tmo_hit_c) tmo_q <= '0;
      else                                       tmo_q <= tmo_q + TMO_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HUNT: if (byte_ok_c && bus.rx_byte == SOF) state_d = ST_CMD;
      ST_CMD:  if (byte_ok_c) state_d = ST_ADDR;
      ST_ADDR: if (byte_ok_c) state_d = (cmd_q == CMD_WR) ? ST_DH : ST_CHK;
      ST_DH:   if (byte_ok_c) state_d = ST_DL;
      ST_DL:   if (byte_ok_c) state_d = ST_CHK;
      ST_CHK:  if (byte_ok_c) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_TX;
      ST_TX:   if (tx_done) state_d = ST_HUNT;
      default: state_d = ST_HUNT;
    endcase
    if (tmo_hit_c) state_d = ST_HUNT;
  end

  // Frame field capture and running checksum.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cmd_q     <= 8'h00;
      addr_q    <= 8'h00;
      dh_q      <= 8'h00;
      dl_q      <= 8'h00;
      chk_q     <= 8'h00;
      chk_acc_q <= 8'h00;
    end else if (byte_ok_c) begin
      case (state_q)
        ST_CMD:  begin cmd_q  <= bus.rx_byte; chk_acc_q <= bus.rx_byte;             end
        ST_ADDR: begin addr_q <= bus.rx_byte; chk_acc_q <= chk_acc_q ^ bus.rx_byte; end
        ST_DH:   begin dh_q   <= bus.rx_byte; chk_acc_q <= chk_acc_q ^ bus.rx_byte; end
        ST_DL:   begin dl_q   <= bus.rx_byte; chk_acc_q <= chk_acc_q ^ bus.rx_byte; end
        ST_CHK:  chk_q <= bus.rx_byte;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      kp       <= KP_RST;
      ki       <= KI_RST;
      kd       <= KD_RST;
      setpoint <= SP_RST;
      cfg_upd  <= 1'b0;
      err_cnt  <= 8'h00;
    end else begin
      cfg_upd <= wr_en_c;
      if (wr_en_c) begin
        case (addr_q[1:0])
          ADDR_KP: kp       <= {dh_q, dl_q};
          ADDR_KI: ki       <= {dh_q, dl_q};
          ADDR_KD: kd       <= {dh_q, dl_q};
          default: setpoint <= {dh_q, dl_q};
        endcase
      end
      if (((state_q == ST_EXEC) && !frame_ok_c) || tmo_hit_c) begin
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    rd_val_c = kp;
    case (addr_q[1:0])
      ADDR_KP: rd_val_c = kp;
      ADDR_KI: rd_val_c = ki;
      ADDR_KD: rd_val_c = kd;
      ADDR_SP: rd_val_c = setpoint;
      default: rd_val_c = kp;
    endcase
  end

  always_comb begin
    reply_c = '0;
    if (!frame_ok_c) begin
      reply_c.len = 2'd1;
      reply_c.b0  = NAK;
    end else if (cmd_q == CMD_WR) begin
      reply_c.len = 2'd1;
      reply_c.b0  = ACK;
    end else begin
      reply_c.len = 2'd3;
      reply_c.b0  = rd_val_c[15:8];
      reply_c.b1  = rd_val_c[7:0];
      reply_c.b2  = rd_val_c[15:8] ^ rd_val_c[7:0];
    end
  end

  uart_tx_seq u_tx_seq (
    .clk_in    (clk_in),
    .reset     (reset),
    .start     (tx_start_c),
    .reply     (reply_c),
    .send_rdy  (bus.send_rdy),
    .send      (bus.send),
    .send_data (bus.send_data),
    .done      (tx_done)
  );

endmodule
